// File: rtl/imm_pkg.sv
// Shared opcode constants, extension kinds and occupancy states for the
// decode-side immediate stage.
package imm_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    typedef enum logic [1:0] {
        EXT_NONE = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_SIGN = 2'd2,
        EXT_LUI  = 2'd3
    } ext_kind_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational opcode classifier and immediate extender.
// IMM_BRANCH_SHIFT_EN: branch immediates come out pre-scaled by 4.
module imm_extend_core
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic [1:0]  kind
);

    logic [5:0]  op;
    logic [15:0] imm16;
    logic [31:0] sext;

    assign op    = instr[31:26];
    assign imm16 = instr[15:0];
    assign sext  = {{16{imm16[15]}}, imm16};

    always_comb begin
        imm  = 32'h0;
        kind = EXT_NONE;
        case (op)
            OP_LUI: begin
                imm  = {imm16, 16'h0};
                kind = EXT_LUI;
            end
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
`ifdef IMM_BRANCH_SHIFT_EN
                imm  = {{14{imm16[15]}}, imm16, 2'b00};
`else
                imm  = sext;
`endif
                kind = EXT_SIGN;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                imm  = sext;
                kind = EXT_SIGN;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                imm  = {16'h0, imm16};
                kind = EXT_ZERO;
            end
            default: begin
                imm  = 32'h0;
                kind = EXT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode immediate stage: extends on the input side, then a 2-entry skid
// buffer (main + skid) so in_ready depends only on registered state.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [1:0]       out_kind,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] imm_cnt
);

    occ_state_t      state_q, state_d;
    logic [31:0]     ext_imm;
    logic [1:0]      ext_kind;
    logic [31:0]     main_imm_q, skid_imm_q;
    logic [1:0]      main_kind_q, skid_kind_q;
    logic [PC_W-1:0] main_pc_q, skid_pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic            accept, issue;
    logic            load_main_in, load_skid, skid_to_main;

    imm_extend_core u_ext (
        .instr (in_instr),
        .imm   (ext_imm),
        .kind  (ext_kind)
    );

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_imm   = main_imm_q;
    assign out_kind  = main_kind_q;
    assign out_pc    = main_pc_q;
    assign imm_cnt   = cnt_q;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load_main_in = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only an issue can move us
                    if (issue) begin
                        state_d      = ST_ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm_q  <= '0;
            main_kind_q <= '0;
            main_pc_q   <= '0;
        end else if (load_main_in) begin
            main_imm_q  <= ext_imm;
            main_kind_q <= ext_kind;
            main_pc_q   <= in_pc;
        end else if (skid_to_main) begin
            main_imm_q  <= skid_imm_q;
            main_kind_q <= skid_kind_q;
            main_pc_q   <= skid_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm_q  <= '0;
            skid_kind_q <= '0;
            skid_pc_q   <= '0;
        end else if (load_skid) begin
            skid_imm_q  <= ext_imm;
            skid_kind_q <= ext_kind;
            skid_pc_q   <= in_pc;
        end
    end

    // Flushed issues do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (issue && !flush && main_kind_q != EXT_NONE && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, flush;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] in_instr, in_pc;
    logic [31:0] out_imm, out_imm2, out_pc, out_pc2;
    logic [1:0]  out_kind, out_kind2;
    logic [15:0] imm_cnt;
    logic [1:0]  imm_cnt2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  kind;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   mcnt;

`ifdef IMM_BRANCH_SHIFT_EN
    localparam logic [31:0] BEQ_EXP = 32'hFFFF_FFFC;
`else
    localparam logic [31:0] BEQ_EXP = 32'hFFFF_FFFF;
`endif

    always #5 clk = ~clk;

    imm_decode_stage #(.PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_kind(out_kind), .out_pc(out_pc), .imm_cnt(imm_cnt)
    );

    imm_decode_stage #(.PC_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_imm(out_imm2),
        .out_kind(out_kind2), .out_pc(out_pc2), .imm_cnt(imm_cnt2)
    );

    function automatic ent_t ref_ext(input logic [31:0] instr, input logic [31:0] pc);
        ent_t e;
        int   op;
        int   s;
        op     = int'(instr[31:26]);
        s      = int'(instr[15:0]);
        if (s >= 32768) s = s - 65536;
        e.pc   = pc;
        e.imm  = 32'h0;
        e.kind = 2'd0;
        if (op == 'h0F) begin
            e.imm  = int'(instr[15:0]) * 65536;
            e.kind = 2'd3;
        end else if (op == 1 || (op >= 4 && op <= 11) || op == 'h23 || op == 'h2B) begin
            e.imm  = s;
`ifdef IMM_BRANCH_SHIFT_EN
            if (op == 1 || (op >= 4 && op <= 7)) e.imm = s * 4;
`endif
            e.kind = 2'd2;
        end else if (op >= 12 && op <= 14) begin
            e.imm  = int'(instr[15:0]);
            e.kind = 2'd1;
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input int op, input int imm16);
        logic [5:0]  o;
        logic [15:0] i;
        o = 6'(op);
        i = 16'(imm16);
        return {o, 10'h15A, i};
    endfunction

    // Drive one cycle (inputs set at posedge+1) and advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        bit acc, iss;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < 2);
        iss = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (iss) begin
                if (q[0].kind != 2'd0) mcnt++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(ref_ext(ins, pc));
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; flush = 0; in_instr = 0; in_pc = 0;
        q.delete();
        mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_imm !== 32'h0 || out_kind !== 2'd0 || out_pc !== 32'h0 || imm_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: imm=%h kind=%0d pc=%h cnt=%0d want zeros",
                     out_imm, out_kind, out_pc, imm_cnt);
        end
        do_reset();
    endtask

    task automatic test_kinds();
        logic [31:0] ins[4];
        logic [31:0] eimm[4];
        logic [1:0]  ekind[4];
        logic [15:0] ecnt[4];
        ins[0] = mk('h08, 'hFFFC); eimm[0] = 32'hFFFF_FFFC; ekind[0] = 2'd2; ecnt[0] = 1;
        ins[1] = mk('h0D, 'h8001); eimm[1] = 32'h0000_8001; ekind[1] = 2'd1; ecnt[1] = 2;
        ins[2] = mk('h0F, 'h1234); eimm[2] = 32'h1234_0000; ekind[2] = 2'd3; ecnt[2] = 3;
        ins[3] = mk('h00, 'h5555); eimm[3] = 32'h0;         ekind[3] = 2'd0; ecnt[3] = 3;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ins[i], 32'h1000 + 4 * i, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_imm !== eimm[i] || out_kind !== ekind[i]
                || out_pc !== 32'h1000 + 4 * i) begin
                errors++;
                $display("FAIL kind_%0d: v=%b imm=%h kind=%0d pc=%h want 1 %h %0d %h", i,
                         out_valid, out_imm, out_kind, out_pc, eimm[i], ekind[i], 32'h1000 + 4 * i);
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || imm_cnt !== ecnt[i]) begin
                errors++;
                $display("FAIL cnt_%0d: v=%b cnt=%0d want 0 %0d", i, out_valid, imm_cnt, ecnt[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[3];
        ent_t e;
        ins[0] = mk('h09, 'h0010);
        ins[1] = mk('h0C, 'hF0F0);
        ins[2] = mk('h23, 'h8000);
        step(1'b1, ins[0], 32'h2000, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_rdy1: in_ready=%b want 1", in_ready);
        end
        step(1'b1, ins[1], 32'h2004, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_rdy2: in_ready=%b want 0", in_ready);
        end
        step(1'b1, ins[2], 32'h2008, 1'b0, 1'b0);
        e = ref_ext(ins[0], 32'h2000);
        checks++;
        if (out_imm !== e.imm || out_pc !== 32'h2000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: imm=%h pc=%h rdy=%b want %h 2000 0", out_imm, out_pc, in_ready, e.imm);
        end
        for (int i = 0; i < 3; i++) begin
            e = ref_ext(ins[i], 32'h2000 + 4 * i);
            checks++;
            if (out_valid !== 1'b1 || out_imm !== e.imm || out_kind !== e.kind || out_pc !== e.pc) begin
                errors++;
                $display("FAIL b2b_order_%0d: v=%b imm=%h kind=%0d pc=%h want 1 %h %0d %h", i,
                         out_valid, out_imm, out_kind, out_pc, e.imm, e.kind, e.pc);
            end
            step(1'b1, ins[2], 32'h2008, 1'b1, 1'b0);
            if (i == 1) begin
                in_valid = 1'b0;
            end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        step(1'b1, mk('h08, 1), 32'h3000, 1'b0, 1'b0);
        step(1'b1, mk('h08, 2), 32'h3004, 1'b0, 1'b0);
        c0 = imm_cnt;
        step(1'b1, mk('h08, 3), 32'h3008, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_cnt !== c0) begin
            errors++;
            $display("FAIL flush: v=%b rdy=%b cnt=%0d want 0 1 %0d", out_valid, in_ready, imm_cnt, c0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || imm_cnt !== c0) begin
            errors++;
            $display("FAIL flush_after: v=%b cnt=%0d want 0 %0d", out_valid, imm_cnt, c0);
        end
    endtask

    task automatic test_branch_and_sat();
        do_reset();
        step(1'b1, mk('h04, 'hFFFF), 32'h4000, 1'b0, 1'b0);
        checks++;
        if (out_imm !== BEQ_EXP || out_kind !== 2'd2) begin
            errors++;
            $display("FAIL beq: imm=%h kind=%0d want %h 2", out_imm, out_kind, BEQ_EXP);
        end
        for (int i = 0; i < 5; i++) step(1'b1, mk('h0E, i), 32'h4004 + 4 * i, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (imm_cnt2 !== 2'd3 || imm_cnt !== 16'd6) begin
            errors++;
            $display("FAIL sat: cnt2=%0d cnt=%0d want 3 6", imm_cnt2, imm_cnt);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, mk('h08, 7), 32'h5000, 1'b1, 1'b0);
        step(1'b1, mk('h08, 8), 32'h5004, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imm_cnt !== 16'h0 || imm_cnt2 !== 2'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: v=%b cnt=%0d cnt2=%0d rdy=%b want 0 0 0 1",
                     out_valid, imm_cnt, imm_cnt2, in_ready);
        end
        do_reset();
    endtask

    task automatic test_random();
        int ops[16] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h08, 'h0A,
                        'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B, 'h3F};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = {6'(ops[$urandom_range(15)]), 26'($urandom)};
            step($urandom_range(3) != 0, ins, $urandom, $urandom_range(2) != 0,
                 $urandom_range(19) == 0);
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_hs@%0d: v=%b rdy=%b want %b %b", n, out_valid, in_ready,
                         q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++;
                if (out_imm !== q[0].imm || out_kind !== q[0].kind || out_pc !== q[0].pc) begin
                    errors++;
                    $display("FAIL rnd_data@%0d: imm=%h kind=%0d pc=%h want %h %0d %h", n,
                             out_imm, out_kind, out_pc, q[0].imm, q[0].kind, q[0].pc);
                end
            end
            checks++;
            if (imm_cnt !== 16'(mcnt) || imm_cnt2 !== 2'((mcnt > 3) ? 3 : mcnt)) begin
                errors++;
                $display("FAIL rnd_cnt@%0d: cnt=%0d cnt2=%0d model=%0d", n, imm_cnt, imm_cnt2, mcnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; flush = 0; in_instr = 0; in_pc = 0;
        q.delete();
        mcnt = 0;
        test_reset();
        test_kinds();
        test_back_to_back();
        test_flush();
        test_branch_and_sat();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Decode-side immediate stage of the CPU pipeline.
- Accepts fetched 32-bit instructions over a valid/ready handshake and classifies the opcode into an extension kind (none, zero, sign, LUI).
- Registers the 32-bit extended immediate together with the kind and the instruction PC toward execute.
- Contains a 2-entry skid buffer so that in_ready is a registered signal and back-pressure never creates a combinational path from out_ready to in_ready.

Parameters:
- PC_W, 32, width of the PC carried alongside each instruction.
- CNT_W, 16, width of the saturating count of immediates issued.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept an instruction; registered.
- in_instr  input  32  instruction word; opcode is [31:26], immediate is [15:0].
- in_pc  input  PC_W  PC of in_instr.
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  entry available to execute.
- out_ready  input  1  execute accepts the entry.
- out_imm  output  32  extended immediate.
- out_kind  output  2  extension kind: 0 NONE, 1 ZERO, 2 SIGN, 3 LUI.
- out_pc  output  PC_W  PC of the issued entry.
- imm_cnt  output  CNT_W  count of issued entries with kind != NONE; saturates at all-ones.

Behaviour:
- Opcode classification:
  - LUI 0x0F -> LUI: imm = {in_instr[15:0], 16'h0}.
  - 0x01, 0x04–0x0B, 0x23, 0x2B -> SIGN: imm = {16{bit15}, imm16}.
  - 0x0C, 0x0D, 0x0E -> ZERO: imm = {16'h0, imm16}.
  - Every other opcode -> NONE: imm = 0.
- Accept: in_valid & in_ready on an edge.
- Issue: out_valid & out_ready on an edge.
- Occupancy FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register holds an entry; out_valid=1, in_ready=1.
  - FULL: main and skid registers both hold entries; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE; the entry is extended into the main register; latency 1 cycle.
  - ONE + accept & issue -> ONE; main is reloaded with the new entry.
  - ONE + accept only -> FULL; the new entry goes to the skid register.
  - ONE + issue only -> EMPTY.
  - FULL + issue -> ONE; skid moves to main in the same edge.
- In FULL, in_ready=0, so in_valid is ignored.
- Outputs come directly from the main register; no combinational input-to-output path.
- Order is preserved: the skid entry is always younger than the main entry.
- flush:
  - Next state is EMPTY and both entries are discarded.
  - An accept or issue in the same cycle is void; the input is dropped and imm_cnt is not incremented.
  - in_ready=1 on the cycle after a flush.
- imm_cnt:
  - +1 on each issue with out_kind != NONE.
  - Holds at 2^CNT_W-1 when saturated.
  - Unaffected by flush.
- Output stability: while out_valid=1 and out_ready=0, out_imm, out_kind and out_pc hold stable.
- Reset (asynchronous assert, synchronous deassert upstream):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_imm=0, out_kind=0, out_pc=0, imm_cnt=0, skid register cleared.
  - Reset mid-transfer discards all entries.

Optional Feature:
- IMM_BRANCH_SHIFT_EN defined:
  - Branch opcodes (0x01, 0x04–0x07) produce the sign-extended immediate shifted left by 2, i.e. {14{bit15}, imm16, 2'b00}.
  - Kind stays SIGN.
- Undefined: branches receive the plain sign extension.

Decomposition:
- Shared package imm_pkg holds:
  - opcode localparams (OP_LUI, OP_ADDI, OP_ANDI, ...);
  - enum ext_kind_t {EXT_NONE, EXT_ZERO, EXT_SIGN, EXT_LUI};
  - the occupancy state enum.
- One combinational sub-module, imm_extend_core:
  - inputs: instr[31:0];
  - outputs: imm[31:0] and kind.
  - Instanced once, on the input side, so both the main and skid registers load already-extended values.

Test Plan:
- Reset, then accept addi with imm 0xFFFC -> next cycle out_valid=1, out_imm=0xFFFFFFFC, out_kind=SIGN, imm_cnt=1 after issue.
- ori with imm 0x8001 -> out_imm=0x00008001, kind ZERO. lui 0x1234 -> out_imm=0x12340000, kind LUI. R-type instruction -> out_imm=0, kind NONE, imm_cnt unchanged.
- Hold out_ready=0, present three back-to-back instructions:
  - in_ready drops after the second accept; the third is held upstream.
  - Release out_ready -> all three issue in order with unchanged values.
- Stage FULL, assert flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing issued, imm_cnt unchanged.
- Assert rst_n low mid-stream, between clock edges -> out_valid and imm_cnt go to 0 immediately, without waiting for a clock edge.
- beq with imm 0xFFFF:
  - with IMM_BRANCH_SHIFT_EN -> 0xFFFFFFFC;
  - without it -> 0xFFFFFFFF.
  - With CNT_W=2, issue 5 immediates -> imm_cnt saturates at 3.
